// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load plus a counted multi-cycle shift or rotate
// in one of five modes, with serial in/out and a busy/done handshake.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] count,
  input  logic             ser_in,
  output logic [WIDTH-1:0] op,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_RUN  = 1'b1;

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_SHL  = 3'd1;
  localparam logic [2:0] MODE_SHR  = 3'd2;
  localparam logic [2:0] MODE_SRA  = 3'd3;
  localparam logic [2:0] MODE_ROL  = 3'd4;
  localparam logic [2:0] MODE_ROR  = 3'd5;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic             ser_out_q, ser_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [2:0]       mode_q, mode_d;

  logic [WIDTH-1:0] step_op;
  logic             step_ser;

  // Result of one step in the latched mode; modes 6 and 7 fall into HOLD.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    step_op  = op_q;
    step_ser = 1'b0;
    case (mode_q)
      MODE_HOLD: begin
        step_op  = op_q;
        step_ser = 1'b0;
      end
      MODE_SHL: begin
        step_op  = {op_q[WIDTH-2:0], ser_in};
        step_ser = op_q[WIDTH-1];
      end
      MODE_SHR: begin
        step_op  = {ser_in, op_q[WIDTH-1:1]};
        step_ser = op_q[0];
      end
      MODE_SRA: begin
        step_op  = {op_q[WIDTH-1], op_q[WIDTH-1:1]};
        step_ser = op_q[0];
      end
      MODE_ROL: begin
        step_op  = {op_q[WIDTH-2:0], op_q[WIDTH-1]};
        step_ser = op_q[WIDTH-1];
      end
      MODE_ROR: begin
        step_op  = {op_q[0], op_q[WIDTH-1:1]};
        step_ser = op_q[0];
      end
      default: begin
        step_op  = op_q;
        step_ser = 1'b0;
      end
    endcase
  end

  // Next-state logic; priority is load_en > start > shift step.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    ser_out_d   = ser_out_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    remaining_d = remaining_q;
    mode_d      = mode_q;

    if (load_en) begin
      // A load aborts any running command silently; ser_out keeps its last value.
      op_d        = load_val;
      state_d     = STATE_IDLE;
      busy_d      = 1'b0;
      remaining_d = '0;
    end else if (state_q == STATE_IDLE) begin
      if (start) begin
        if (count != '0) begin
          mode_d      = mode;
          remaining_d = count;
          busy_d      = 1'b1;
          state_d     = STATE_RUN;
        end else begin
          done_d = 1'b1;
        end
      end
    end else begin
      op_d        = step_op;
      ser_out_d   = step_ser;
      remaining_d = remaining_q - CNT_W'(1);
      if (remaining_q == CNT_W'(1)) begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = STATE_IDLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= STATE_IDLE;
      op_q        <= '0;
      ser_out_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      remaining_q <= '0;
      mode_q      <= MODE_HOLD;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      ser_out_q   <= ser_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      remaining_q <= remaining_d;
      mode_q      <= mode_d;
    end
  end

  assign op      = op_q;
  assign ser_out = ser_out_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8, CNT_W=4): a table of per-cycle
// vectors checked through a scoreboard queue, plus hand-written reset sequences.
module tb_univ_shift_reg;

  logic       clk;
  logic       rst;
  logic       load_en;
  logic [7:0] load_val;
  logic       start;
  logic [2:0] mode;
  logic [3:0] count;
  logic       ser_in;
  logic [7:0] op;
  logic       ser_out;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      name;
    logic       load_en;
    logic [7:0] load_val;
    logic       start;
    logic [2:0] mode;
    logic [3:0] count;
    logic       ser_in;
    logic [7:0] op;
    logic       so;
    logic       busy;
    logic       done;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] op;
    logic       so;
    logic       busy;
    logic       done;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .load_en (load_en),
    .load_val(load_val),
    .start   (start),
    .mode    (mode),
    .count   (count),
    .ser_in  (ser_in),
    .op      (op),
    .ser_out (ser_out),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic le, input logic [7:0] lv, input logic st,
                     input logic [2:0] md, input logic [3:0] cn, input logic si,
                     input logic [7:0] eop, input logic eso, input logic eb, input logic ed);
    vec_t v;
    v.name = n; v.load_en = le; v.load_val = lv; v.start = st; v.mode = md;
    v.count = cn; v.ser_in = si; v.op = eop; v.so = eso; v.busy = eb; v.done = ed;
    vecs.push_back(v);
  endtask

  // Drive one vector before the edge, queue its expectation, then check after the edge.
  task automatic apply(input vec_t v);
    exp_t e;
    exp_t got;
    @(negedge clk);
    load_en = v.load_en; load_val = v.load_val; start = v.start;
    mode = v.mode; count = v.count; ser_in = v.ser_in;
    e.name = v.name; e.op = v.op; e.so = v.so; e.busy = v.busy; e.done = v.done;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      got = exp_q.pop_front();
      check({got.name, ".op"},   32'(op),      32'(got.op));
      check({got.name, ".so"},   32'(ser_out), 32'(got.so));
      check({got.name, ".busy"}, 32'(busy),    32'(got.busy));
      check({got.name, ".done"}, 32'(done),    32'(got.done));
    end
  endtask

  task automatic check_reset_outputs(input string n);
    check({n, ".op"},   32'(op),      32'h00);
    check({n, ".so"},   32'(ser_out), 32'h0);
    check({n, ".busy"}, 32'(busy),    32'h0);
    check({n, ".done"}, 32'(done),    32'h0);
  endtask

  initial begin
    // Reset held with a pending load: outputs must stay at reset values.
    rst = 1'b1; load_en = 1'b1; load_val = 8'hA5; start = 1'b0;
    mode = 3'd0; count = 4'd0; ser_in = 1'b0;
    #1;
    check_reset_outputs("rst_t0");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_reset_outputs("rst_hold");
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_first_load.op", 32'(op), 32'hA5);
    check("rst_first_load.busy", 32'(busy), 32'h0);

    // Legacy rotate: ROL x8 from 0x01.
    add("rol_load",  1, 8'h01, 0, 0, 0, 0, 8'h01, 0, 0, 0);
    add("rol_start", 0, 8'h00, 1, 4, 8, 0, 8'h01, 0, 1, 0);
    add("rol_s1",    0, 8'h00, 0, 0, 0, 0, 8'h02, 0, 1, 0);
    add("rol_s2",    0, 8'h00, 0, 0, 0, 0, 8'h04, 0, 1, 0);
    add("rol_s3",    0, 8'h00, 0, 0, 0, 0, 8'h08, 0, 1, 0);
    add("rol_s4",    0, 8'h00, 0, 0, 0, 0, 8'h10, 0, 1, 0);
    add("rol_s5",    0, 8'h00, 0, 0, 0, 0, 8'h20, 0, 1, 0);
    add("rol_s6",    0, 8'h00, 0, 0, 0, 0, 8'h40, 0, 1, 0);
    add("rol_s7",    0, 8'h00, 0, 0, 0, 0, 8'h80, 0, 1, 0);
    add("rol_s8",    0, 8'h00, 0, 0, 0, 0, 8'h01, 1, 0, 1);
    add("rol_after", 0, 8'h00, 0, 0, 0, 0, 8'h01, 1, 0, 0);
    // Arithmetic shift right x3 from 0x81; ser_in must be ignored.
    add("sra_load",  1, 8'h81, 0, 0, 0, 1, 8'h81, 1, 0, 0);
    add("sra_start", 0, 8'h00, 1, 3, 3, 1, 8'h81, 1, 1, 0);
    add("sra_s1",    0, 8'h00, 0, 0, 0, 1, 8'hC0, 1, 1, 0);
    add("sra_s2",    0, 8'h00, 0, 0, 0, 1, 8'hE0, 0, 1, 0);
    add("sra_s3",    0, 8'h00, 0, 0, 0, 1, 8'hF0, 0, 0, 1);
    add("sra_after", 0, 8'h00, 0, 0, 0, 0, 8'hF0, 0, 0, 0);
    // Serial fill: SHL with ones, then SHR with zeros; both land on 0x0F.
    add("shl_load",  1, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0, 0);
    add("shl_start", 0, 8'h00, 1, 1, 4, 1, 8'h00, 0, 1, 0);
    add("shl_s1",    0, 8'h00, 0, 0, 0, 1, 8'h01, 0, 1, 0);
    add("shl_s2",    0, 8'h00, 0, 0, 0, 1, 8'h03, 0, 1, 0);
    add("shl_s3",    0, 8'h00, 0, 0, 0, 1, 8'h07, 0, 1, 0);
    add("shl_s4",    0, 8'h00, 0, 0, 0, 1, 8'h0F, 0, 0, 1);
    add("shr_load",  1, 8'hF0, 0, 0, 0, 0, 8'hF0, 0, 0, 0);
    add("shr_start", 0, 8'h00, 1, 2, 4, 0, 8'hF0, 0, 1, 0);
    add("shr_s1",    0, 8'h00, 0, 0, 0, 0, 8'h78, 0, 1, 0);
    add("shr_s2",    0, 8'h00, 0, 0, 0, 0, 8'h3C, 0, 1, 0);
    add("shr_s3",    0, 8'h00, 0, 0, 0, 0, 8'h1E, 0, 1, 0);
    add("shr_s4",    0, 8'h00, 0, 0, 0, 0, 8'h0F, 0, 0, 1);
    // Back-to-back: start accepted on the edge where done is visible.
    add("b2b_start", 0, 8'h00, 1, 5, 1, 0, 8'h0F, 0, 1, 0);
    add("b2b_s1",    0, 8'h00, 0, 0, 0, 0, 8'h87, 1, 0, 1);
    // Zero count: immediate done, no busy, op unchanged.
    add("zero_start", 0, 8'h00, 1, 4, 0, 0, 8'h87, 1, 0, 1);
    add("zero_after", 0, 8'h00, 0, 0, 0, 0, 8'h87, 1, 0, 0);
    // HOLD clears ser_out but still counts steps; mode 7 behaves as HOLD.
    add("hold_start", 0, 8'h00, 1, 0, 2, 1, 8'h87, 1, 1, 0);
    add("hold_s1",    0, 8'h00, 0, 0, 0, 1, 8'h87, 0, 1, 0);
    add("hold_s2",    0, 8'h00, 0, 0, 0, 1, 8'h87, 0, 0, 1);
    add("rol1_start", 0, 8'h00, 1, 4, 1, 0, 8'h87, 0, 1, 0);
    add("rol1_s1",    0, 8'h00, 0, 0, 0, 0, 8'h0F, 1, 0, 1);
    add("m7_start",   0, 8'h00, 1, 7, 1, 1, 8'h0F, 1, 1, 0);
    add("m7_s1",      0, 8'h00, 0, 0, 0, 1, 8'h0F, 0, 0, 1);
    // Abort: ROR x5 from 0x01, ignored start while busy, load after two steps.
    add("abort_load",  1, 8'h01, 0, 0, 0, 0, 8'h01, 0, 0, 0);
    add("abort_start", 0, 8'h00, 1, 5, 5, 0, 8'h01, 0, 1, 0);
    add("abort_s1",    0, 8'h00, 0, 0, 0, 0, 8'h80, 1, 1, 0);
    add("abort_s2_st", 0, 8'h00, 1, 1, 3, 1, 8'h40, 0, 1, 0);
    add("abort_ld",    1, 8'h3C, 1, 4, 9, 0, 8'h3C, 0, 0, 0);
    add("abort_idle1", 0, 8'h00, 0, 0, 0, 0, 8'h3C, 0, 0, 0);
    add("abort_idle2", 0, 8'h00, 0, 0, 0, 0, 8'h3C, 0, 0, 0);
    add("abort_idle3", 0, 8'h00, 0, 0, 0, 0, 8'h3C, 0, 0, 0);
    // Lead-in for mid-run reset: ROL x10 from 0x01, three steps.
    add("mrst_load",  1, 8'h01, 0, 0, 0, 0, 8'h01, 0, 0, 0);
    add("mrst_start", 0, 8'h00, 1, 4, 10, 0, 8'h01, 0, 1, 0);
    add("mrst_s1",    0, 8'h00, 0, 0, 0, 0, 8'h02, 0, 1, 0);
    add("mrst_s2",    0, 8'h00, 0, 0, 0, 0, 8'h04, 0, 1, 0);
    add("mrst_s3",    0, 8'h00, 0, 0, 0, 0, 8'h08, 0, 1, 0);

    foreach (vecs[i]) apply(vecs[i]);

    // Asynchronous reset mid-command takes effect before the next edge.
    @(negedge clk);
    load_en = 1'b0; start = 1'b0; ser_in = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("mrst_async");
    @(posedge clk);
    #1;
    check_reset_outputs("mrst_held");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      check("mrst_post.done", 32'(done), 32'h0);
      check("mrst_post.busy", 32'(busy), 32'h0);
      check("mrst_post.op",   32'(op),   32'h00);
    end

    if (exp_q.size() != 0) check("scoreboard_leftover", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
